// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide engine.
//   - mdu_op_e    : operation encodings as driven on op_i
//   - mdu_state_e : sequencer state encodings
//   - RST_LVL     : level of rst that resets the engine (active-low)
//   - op helpers  : decode of the divide / signed bits of an op
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    MDU_IDLE  = 3'd0,
    MDU_PREP  = 3'd1,
    MDU_CALC  = 3'd2,
    MDU_FIXUP = 3'd3,
    MDU_DONE  = 3'd4
  } mdu_state_e;

  localparam logic RST_LVL = 1'b0;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_mdu_step.sv
// mdu_step: one combinational iteration of the multiply/divide datapath.
// Ports:
//   part_i    [2W] : partial value; multiply {acc_hi, multiplier bits},
//                    divide {remainder, dividend/quotient bits}
//   operand_i [W]  : multiplicand (multiply) or divisor (divide)
//   is_div_i       : 1 = restoring-divide step, 0 = shift-add step
//   part_o    [2W] : next partial value (bit 0 is 0 on divide steps)
//   q_o            : quotient bit produced by a divide step (0 on multiply)
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] part_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] part_o,
  output logic               q_o
);

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH:0]   w_sum;

  always_comb begin
    // Remainder shifted left with the next dividend bit brought down.
    w_rem_sh = {part_i[2*WIDTH-1:WIDTH], part_i[WIDTH-1]};
    // When the subtraction succeeds the true difference is below the
    // divisor, so the low WIDTH bits of the modular result are exact.
    w_diff   = w_rem_sh[WIDTH-1:0] - operand_i;
    w_sum    = {1'b0, part_i[2*WIDTH-1:WIDTH]}
             + (part_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
    part_o   = '0;
    q_o      = 1'b0;
    if (is_div_i) begin
      q_o    = (w_rem_sh >= {1'b0, operand_i});
      part_o = {(q_o ? w_diff : w_rem_sh[WIDTH-1:0]), part_i[WIDTH-2:0], 1'b0};
    end else begin
      part_o = {w_sum, part_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULTU/MULT/DIVU/DIV engine for the EX stage.
// Sequence IDLE -> PREP -> CALC (WIDTH cycles) -> FIXUP -> DONE -> IDLE.
// Optional build macro MDU_FAST_MULT_EN: multiplies skip CALC and use one
// registered native multiply in PREP (done in cycle 3); divides unchanged.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   start_i, op_i     : request and op (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   opa_i, opb_i      : multiplicand/dividend, multiplier/divisor
//   annul_i           : abort current operation, back to IDLE
//   stall_req_o       : EX stall request, drops in the DONE cycle
//   busy_o            : engine not IDLE
//   done_o            : one-cycle result-valid pulse
//   hi_o, lo_o        : product hi/lo, or remainder/quotient
//   div_zero_o        : last divide had a zero divisor
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  output logic             stall_req_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v,
                                             input logic en);
    logic [WIDTH-1:0] u;
    u = v;
    // MIN maps onto itself, which is the correct unsigned magnitude.
    return (en && v < 0) ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v,
                                             input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v,
                                                input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  mdu_state_e         r_state, w_nxt;
  logic [CNT_W-1:0]   r_cnt;
  mdu_op_e            r_op;
  logic [WIDTH-1:0]   r_opa, r_opb, r_opd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg_lo, r_neg_hi;

  logic               w_is_div, w_is_signed, w_div_zero;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [2*WIDTH-1:0] w_step_part;
  logic               w_step_q;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

  assign w_is_div    = op_is_div(r_op);
  assign w_is_signed = op_is_signed(r_op);
  assign w_div_zero  = w_is_div && (r_opb == '0);
  assign w_abs_a     = abs_w(r_opa, w_is_signed);
  assign w_abs_b     = abs_w(r_opb, w_is_signed);

  assign busy_o      = (r_state != MDU_IDLE);
  assign done_o      = (r_state == MDU_DONE);
  assign stall_req_o = ((r_state == MDU_IDLE) && start_i)
                    || ((r_state != MDU_IDLE) && (r_state != MDU_DONE));

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .part_i    (r_acc),
    .operand_i (r_opd),
    .is_div_i  (w_is_div),
    .part_o    (w_step_part),
    .q_o       (w_step_q)
  );

  always_comb begin
    w_fix_hi = '0;
    w_fix_lo = '0;
    if (w_is_div) begin
      w_fix_lo = neg_w(r_acc[WIDTH-1:0], r_neg_lo);
      w_fix_hi = neg_w(r_acc[2*WIDTH-1:WIDTH], r_neg_hi);
    end else begin
      {w_fix_hi, w_fix_lo} = neg_2w(r_acc, r_neg_lo);
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      MDU_IDLE:  if (start_i) w_nxt = MDU_PREP;
      MDU_PREP: begin
        if (w_div_zero) begin
          w_nxt = MDU_DONE;
        end else begin
`ifdef MDU_FAST_MULT_EN
          w_nxt = w_is_div ? MDU_CALC : MDU_FIXUP;
`else
          w_nxt = MDU_CALC;
`endif
        end
      end
      MDU_CALC:  if (r_cnt == CNT_W'(WIDTH-1)) w_nxt = MDU_FIXUP;
      MDU_FIXUP: w_nxt = MDU_DONE;
      MDU_DONE:  w_nxt = MDU_IDLE;
      default:   w_nxt = MDU_IDLE;
    endcase
    // Abort wins over everything, including a start in IDLE.
    if (annul_i) w_nxt = MDU_IDLE;
  end

  // Control: state and iteration counter
  always_ff @(posedge clk) begin
    if (rst == RST_LVL) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == MDU_PREP)      r_cnt <= '0;
      else if (r_state == MDU_CALC) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Datapath: operand capture, magnitude/sign prep, iteration
  always_ff @(posedge clk) begin
    case (r_state)
      MDU_IDLE: begin
        if (start_i) begin
          r_op  <= mdu_op_e'(op_i);
          r_opa <= opa_i;
          r_opb <= opb_i;
        end
      end
      MDU_PREP: begin
        r_neg_lo <= w_is_signed && (r_opa[WIDTH-1] ^ r_opb[WIDTH-1]);
        r_neg_hi <= w_is_signed && r_opa[WIDTH-1];
        if (w_is_div) begin
          r_opd <= w_abs_b;
          r_acc <= {{WIDTH{1'b0}}, w_abs_a};
        end else begin
`ifdef MDU_FAST_MULT_EN
          r_acc <= {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
`else
          r_opd <= w_abs_a;
          r_acc <= {{WIDTH{1'b0}}, w_abs_b};
`endif
        end
      end
      MDU_CALC: r_acc <= w_step_part | {{(2*WIDTH-1){1'b0}}, w_step_q};
      default: ;
    endcase
  end

  // Result registers: loaded on entry to DONE, held otherwise
  always_ff @(posedge clk) begin
    if (rst == RST_LVL) begin
      hi_o       <= '0;
      lo_o       <= '0;
      div_zero_o <= 1'b0;
    end else if (!annul_i) begin
      if ((r_state == MDU_PREP) && w_div_zero) begin
        hi_o       <= r_opa;
        lo_o       <= '1;
        div_zero_o <= 1'b1;
      end else if (r_state == MDU_FIXUP) begin
        hi_o <= w_fix_hi;
        lo_o <= w_fix_lo;
        if (w_is_div) div_zero_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide engine that serves the EX stage for MULT/MULTU/DIV/DIVU.
- It generalises the existing single-op signed-multiply start/finished handshake to a WIDTH-parametrised unit with four ops, cancel, divide-by-zero handling and a registered {hi,lo} result.
- EX drives start and operands, and holds its stall request until done. The result goes to the hi/lo write path.

Parameters:
- WIDTH, 32, operand width; results are 2*WIDTH ({hi,lo}).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- start_i  in  1  request; sampled only in IDLE.
- op_i  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start_i.
- opa_i  in  WIDTH  multiplicand/dividend.
- opb_i  in  WIDTH  multiplier/divisor.
- annul_i  in  1  abort the current operation (branch flush/exception).
- stall_req_o  out  1  EX stall request.
- busy_o  out  1  engine occupied (state != IDLE).
- done_o  out  1  one-cycle pulse; result valid.
- hi_o  out  WIDTH  product high half / remainder.
- lo_o  out  WIDTH  product low half / quotient.
- div_zero_o  out  1  sticky-with-result: last DIV/DIVU had opb==0.

Behaviour:
- Reset: on a clk edge with rst==0: state=IDLE, counter=0, done_o=0, hi_o=0, lo_o=0, div_zero_o=0. Reset takes priority over every other input, including mid-operation.
- FSM: IDLE -> PREP -> CALC -> FIXUP -> DONE -> IDLE.
- IDLE: start_i=1 latches op and operands, then goes to PREP.
- PREP:
  - Signed ops take absolute values and record result signs: product sign = a^b; quotient sign = a^b; remainder sign = a.
  - DIV/DIVU with opb==0: skip to DONE with lo=all-ones, hi=opa, div_zero_o=1.
- CALC: exactly WIDTH cycles.
  - Multiply: shift-add, one bit per cycle.
  - Divide: restoring divide, one quotient bit per cycle.
- FIXUP: conditional two's-complement negation of product / quotient / remainder.
- DONE: hi_o/lo_o register the result; done_o=1 for this cycle only; next state is IDLE.
- Latency: start accepted in cycle 0; done_o is high in cycle WIDTH+3 (35 for WIDTH=32). Divide-by-zero gives done_o in cycle 2.
- Outputs hi_o/lo_o/div_zero_o hold their values until the next DONE or reset.
- Arithmetic rules:
  - Unsigned ops treat operands as zero-extended.
  - Division truncates toward zero.
  - DIV of MIN by -1 gives lo=MIN, hi=0; no trap.
- stall_req_o = (state==IDLE & start_i) | (state!=IDLE & state!=DONE). It drops in the DONE cycle so EX advances with the result.
- annul_i=1 in any state: go to IDLE next cycle. No done_o; hi_o/lo_o/div_zero_o are unchanged.
- annul_i and start_i both high in IDLE: annul wins and the start is ignored.
- start_i while busy: ignored; EX is stalled, so this is legal only as a held level.
- start_i high in the DONE cycle: ignored. A new op is accepted only from IDLE, one cycle later.

Optional Feature:
- Macro: MDU_FAST_MULT_EN.
- Defined:
  - MULT/MULTU bypass CALC. PREP computes the full product with one registered native multiply, then goes to FIXUP.
  - done_o is high in cycle 3.
  - Divide is unchanged.
- Undefined: multiplies use the iterative path with WIDTH+3 latency.
- Results are identical either way.

Decomposition:
- Shared include (defines.v) carries:
  - op encodings MDU_MULTU/MDU_MULT/MDU_DIVU/MDU_DIV;
  - state encodings MDU_IDLE/PREP/CALC/FIXUP/DONE;
  - the reset-level constant for active-low rst.
- One sub-module: mdu_step. It is a combinational single iteration that takes partial remainder/product, the operand and op class, and returns the next partial value plus the quotient bit. It is instantiated once in CALC.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done_o at cycle 35; hi=0xFFFFFFFE, lo=0x00000001; stall_req_o high in cycles 0-34, low at 35.
- MULT 0xFFFFFFFE x 0x00000003 (-2x3) -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; repeat with MDU_FAST_MULT_EN -> same values, done_o at cycle 3.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100 / 7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5 / 0 -> done_o at cycle 2, lo=0xFFFFFFFF, hi=5, div_zero_o=1.
- Start MULTU, assert annul_i at cycle 10 -> IDLE at cycle 11, no done_o, prior hi/lo retained; start_i+annul_i together in IDLE -> no operation.
- Drive rst=0 for one edge at cycle 20 of a DIV -> all outputs 0, IDLE; a new DIVU 9/3 then completes with lo=3, hi=0.
